// File: rtl/ps2_pkg.sv
// ============================================================================
// Module : ps2_pkg
// Brief  : Shared PS/2 prefix codes, decoder state and held-key type.
//          PS2_KEY_ASCII_EN adds the scan_code2ascii helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } ps2_key_t;

`ifdef PS2_KEY_ASCII_EN
  // Scan-code set 2, unshifted letters/digits plus space and enter.
  function automatic logic [7:0] scan_code2ascii(input logic [7:0] code);
    case (code)
      8'h1C: return 8'h41;  8'h32: return 8'h42;  8'h21: return 8'h43;
      8'h23: return 8'h44;  8'h24: return 8'h45;  8'h2B: return 8'h46;
      8'h34: return 8'h47;  8'h33: return 8'h48;  8'h43: return 8'h49;
      8'h3B: return 8'h4A;  8'h42: return 8'h4B;  8'h4B: return 8'h4C;
      8'h3A: return 8'h4D;  8'h31: return 8'h4E;  8'h44: return 8'h4F;
      8'h4D: return 8'h50;  8'h15: return 8'h51;  8'h2D: return 8'h52;
      8'h1B: return 8'h53;  8'h2C: return 8'h54;  8'h3C: return 8'h55;
      8'h2A: return 8'h56;  8'h1D: return 8'h57;  8'h22: return 8'h58;
      8'h35: return 8'h59;  8'h1A: return 8'h5A;
      8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
      8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
      8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
      8'h46: return 8'h39;  8'h29: return 8'h20;  8'h5A: return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/ps2_held_table.sv
// ============================================================================
// Module : ps2_held_table
// Brief  : Small CAM of currently held {ext, code} keys; inserts into the
//          lowest free slot, removes on match, single-cycle update.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ps2_held_table
  import ps2_pkg::*;
#(
  parameter  int N_HELD = 4,
  localparam int HC_W   = $clog2(N_HELD + 1)
) (
  input  logic            clk,
  input  logic            clrn,
  input  ps2_key_t        key,
  input  logic            insert,
  input  logic            remove,
  output logic            hit,
  output logic [HC_W-1:0] count,
  output logic            full
);

  logic [N_HELD-1:0] w_valid;
  logic [N_HELD-1:0] w_match;
  logic [N_HELD-1:0] w_ins_sel;
  logic              w_found;

  always_comb begin
    w_ins_sel = '0;
    w_found   = 1'b0;
    for (int i = 0; i < N_HELD; i++) begin
      if (!w_valid[i] && !w_found) begin
        w_ins_sel[i] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_HELD; gi++) begin : g_slot
      logic     r_valid;
      ps2_key_t r_key;

      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          r_valid <= 1'b0;
          r_key   <= '0;
        end else if (insert && w_ins_sel[gi]) begin
          r_valid <= 1'b1;
          r_key   <= key;
        end else if (remove && w_match[gi]) begin
          r_valid <= 1'b0;
        end
      end

      assign w_valid[gi] = r_valid;
      assign w_match[gi] = r_valid && (r_key == key);
    end
  endgenerate

  always_comb begin
    count = '0;
    for (int i = 0; i < N_HELD; i++) begin
      count = count + HC_W'(w_valid[i]);
    end
  end

  assign hit  = |w_match;
  assign full = (count == HC_W'(N_HELD));

endmodule

`default_nettype wire

// File: rtl/ps2_key_tracker.sv
// ============================================================================
// Module : ps2_key_tracker
// Brief  : PS/2 FIFO reader, make/break/E0 decoder and held-key tracker.
//          Define PS2_KEY_ASCII_EN to build the ascii lookup.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter  int CNT_W  = 8,
  parameter  int N_HELD = 4,
  localparam int HC_W   = $clog2(N_HELD + 1)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_make,
  output logic [CNT_W-1:0] press_count,
  output logic [HC_W-1:0]  held_count,
  output logic             any_held,
  output logic             held_full,
  output logic             ovf_seen,
  output logic [7:0]       ascii
);

  ps2_state_t r_state;
  ps2_state_t w_cur;
  ps2_state_t w_next;
  ps2_key_t   w_key;
  logic       r_pop;
  logic       w_prefix;
  logic       w_evt;
  logic       w_evt_ext;
  logic       w_evt_make;
  logic       w_hit;
  logic       w_insert;
  logic       w_remove;

  // A pop is never followed directly by another, so a byte is never taken twice.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_pop <= 1'b0;
    else       r_pop <= kb_ready & ~r_pop;
  end

  assign nextdata_n = ~r_pop;

  assign w_cur    = kb_overflow ? ST_IDLE : r_state;
  assign w_prefix = (kb_data == PS2_BREAK) || (kb_data == PS2_EXT);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = w_cur;
    if (r_pop) begin
      case (w_cur)
        ST_IDLE:    w_next = (kb_data == PS2_BREAK) ? ST_BRK :
                             (kb_data == PS2_EXT)   ? ST_EXT : ST_IDLE;
        ST_EXT:     w_next = (kb_data == PS2_BREAK) ? ST_EXT_BRK :
                             (kb_data == PS2_EXT)   ? ST_EXT : ST_IDLE;
        ST_BRK:     w_next = (kb_data == PS2_EXT)   ? ST_EXT_BRK :
                             (kb_data == PS2_BREAK) ? ST_BRK : ST_IDLE;
        ST_EXT_BRK: w_next = w_prefix ? ST_EXT_BRK : ST_IDLE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_evt      = r_pop && !w_prefix;
    w_evt_ext  = (w_cur == ST_EXT) || (w_cur == ST_EXT_BRK);
    w_evt_make = (w_cur == ST_IDLE) || (w_cur == ST_EXT);
  end

  assign w_key    = {w_evt_ext, kb_data};
  // Repeats of a held key are typematic and neither counted nor re-stored.
  assign w_insert = w_evt && w_evt_make && !w_hit;
  assign w_remove = w_evt && !w_evt_make;

  ps2_held_table #(
    .N_HELD (N_HELD)
  ) u_table (
    .clk    (clk),
    .clrn   (clrn),
    .key    (w_key),
    .insert (w_insert),
    .remove (w_remove),
    .hit    (w_hit),
    .count  (held_count),
    .full   (held_full)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_make    <= 1'b0;
      press_count <= '0;
      ovf_seen    <= 1'b0;
    end else begin
      key_valid <= w_evt;
      if (w_evt) begin
        key_code <= kb_data;
        key_ext  <= w_evt_ext;
        key_make <= w_evt_make;
      end
      if (w_insert)    press_count <= press_count + CNT_W'(1);
      if (kb_overflow) ovf_seen    <= 1'b1;
    end
  end

  assign any_held = (held_count != '0);

`ifdef PS2_KEY_ASCII_EN
  assign ascii = key_ext ? 8'h00 : scan_code2ascii(key_code);
`else
  assign ascii = 8'h00;
`endif

endmodule

`default_nettype wire

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Next-generation keyboard front end that sits between ps2_keyboard (FIFO, ready/nextdata_n handshake) and the 7-segment display logic.
- Owns the FIFO read handshake and decodes make/break/extended sequences (F0, E0) into key events.
- Tracks up to N_HELD simultaneously held keys, suppresses typematic repeats and counts distinct presses.
- Output feeds data2seg instances directly.

Parameters:
- CNT_W, 8: width of press counter; wraps modulo 2^CNT_W.
- N_HELD, 4: held-key table depth (1..16).
- HC_W, $clog2(N_HELD+1): width of held_count (localparam, not overridable).

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- kb_data  in  8  FIFO head byte from ps2_keyboard.
- kb_ready  in  1  FIFO non-empty.
- kb_overflow  in  1  FIFO overflow flag.
- nextdata_n  out  1  active-low pop strobe to ps2_keyboard.
- key_valid  out  1  one-cycle pulse per decoded event.
- key_code  out  8  scan code of last event (held until next event).
- key_ext  out  1  last event was E0-prefixed.
- key_make  out  1  1 = press, 0 = release, for last event.
- press_count  out  CNT_W  distinct new presses since reset.
- held_count  out  HC_W  keys currently held.
- any_held  out  1  held_count != 0.
- held_full  out  1  table at N_HELD entries.
- ovf_seen  out  1  sticky: kb_overflow was ever high.
- ascii  out  8  ASCII of key_code (see optional feature).

Behaviour:
Reset (clrn=0, async):
- nextdata_n=1; key_valid=0; key_code=0; key_ext=0; key_make=0.
- press_count=0; held_count=0; held_full=0; ovf_seen=0.
- Table emptied; FSM to IDLE.

Handshake:
- Pop cycle: kb_ready=1 and nextdata_n=1 in the previous cycle → nextdata_n=0 for exactly one cycle, and kb_data is consumed on that cycle.
- The following cycle nextdata_n is forced to 1. Result: at most one pop per 2 cycles and no double consumption.

FSM states: IDLE, EXT, BRK, EXT_BRK. On each pop:
- IDLE:
  - F0 → BRK.
  - E0 → EXT.
  - other → make event (ext=0), back to IDLE.
- EXT:
  - F0 → EXT_BRK.
  - E0 → EXT.
  - other → make event (ext=1), to IDLE.
- BRK:
  - E0 → EXT_BRK.
  - F0 → BRK.
  - other → break event (ext=0), to IDLE.
- EXT_BRK:
  - F0 or E0 → stay.
  - other → break event (ext=1), to IDLE.

Event timing and outputs:
- key_valid pulses the cycle after the pop.
- key_code, key_ext and key_make update in that same cycle.
- Table key = {ext, code}, 9 bits.

Make event:
- Key already in table → repeat: key_valid still pulses with key_make=1; press_count and table unchanged.
- Otherwise → press_count+1.
  - If the table is not full, insert the key and held_count+1.
  - If held_full, the key is not stored; count still increments.

Break event:
- Matching entry removed and held_count-1.
- No match: event emitted, counts unchanged.

Overflow:
- kb_overflow=1 sets ovf_seen (sticky until reset).
- The FSM is forced to IDLE on that cycle; a pending prefix is discarded.

Boundaries:
- press_count wraps 2^CNT_W-1 → 0.
- Pop and overflow in the same cycle: the byte is decoded from IDLE.
- Reset mid-sequence: the prefix is lost.

Optional Feature:
PS2_KEY_ASCII_EN
- Defined: ascii = combinational lookup of key_code via scan_code2ascii. Returns 0 for ext keys and unmapped codes; updates with key_code.
- Undefined: ascii tied to 8'h00 and no lookup logic is built.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0;
  - the FSM state enum;
  - a 9-bit key typedef {ext, code}.
- Sub-module ps2_held_table (N_HELD):
  - lookup hit, insert, remove, count and full;
  - single-cycle update;
  - free slot chosen by lowest index.

Test Plan:
- Make then break: bytes 1C, F0 1C → events (1C, make, ext=0) then (1C, break); press_count=1; held_count 1 then 0.
- Typematic: 1C ×5 → 5 key_valid pulses; press_count=1; held_count=1.
- Extended key: E0 75, E0 F0 75 → events key_ext=1 make then break; 9'h175 inserted and removed; ascii=0.
- Table full (N_HELD=4): makes 1C 32 21 23 2B → held_full=1; press_count=5; held_count=4; break 2B → counts unchanged.
- Handshake: kb_ready held at 1 for 10 cycles → nextdata_n low on alternate cycles only, never two consecutive cycles.
- Overflow: E0 then kb_overflow pulse, then 1C → ovf_seen=1; event 1C with ext=0. Then assert clrn=0 mid-stream → all outputs zero, nextdata_n=1.
